// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : baud_tick_gen
//  Purpose  : Fractional baud-rate tick generator producing oversample, bit and
//             mid-bit clock enables plus a legacy square-wave clkout.
//  Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int          CNT_W    = 16,
  parameter int          FRAC_W   = 4,
  parameter int          OVS      = 16,
  parameter int unsigned DEF_INT  = 78,
  parameter int unsigned DEF_FRAC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    resync,
  input  logic [CNT_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  output logic                    div_pend,
  output logic                    ovs_tick,
  output logic                    bit_tick,
  output logic                    mid_tick,
  output logic [$clog2(OVS)-1:0]  ovs_phase,
  output logic                    clkout
);

  localparam int                PH_W        = $clog2(OVS);
  localparam logic [PH_W-1:0]   c_PH_LAST   = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0]   c_PH_MID_M1 = PH_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0]  c_MIN_INT   = CNT_W'(2);
  localparam logic [CNT_W-1:0]  c_ONE       = CNT_W'(1);

  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_act_int;
  logic [FRAC_W-1:0]  r_act_frac;
  logic [CNT_W-1:0]   r_sh_int;
  logic [FRAC_W-1:0]  r_sh_frac;
  logic               r_pend;
  logic [FRAC_W-1:0]  r_acc;
  logic               r_long;
  logic [PH_W-1:0]    r_phase;
  logic               r_ovs;
  logic               r_bit;
  logic               r_mid;
  logic               r_clk;

  logic [CNT_W-1:0]   w_ieff;
  logic [CNT_W-1:0]   w_last;
  logic [CNT_W-1:0]   w_half_m1;
  logic               w_wrap;
  logic [FRAC_W:0]    w_sum;
  logic               w_apply;

  // Divisors below 2 cannot form a period with a distinct high phase.
  assign w_ieff    = (r_act_int < c_MIN_INT) ? c_MIN_INT : r_act_int;
  assign w_last    = r_long ? w_ieff : (w_ieff - c_ONE);
  assign w_half_m1 = (w_ieff >> 1) - c_ONE;
  assign w_wrap    = en && (r_cnt == w_last);
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_act_frac};
  // The pending flag only reflects loads from earlier edges, so a load
  // coinciding with a wrap waits for the following wrap.
  assign w_apply   = resync ? r_pend : (w_wrap && r_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_long  <= 1'b0;
      r_phase <= '0;
    end else if (resync) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_long  <= 1'b0;
      r_phase <= '0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_acc   <= w_sum[FRAC_W-1:0];
      r_long  <= w_sum[FRAC_W];
      r_phase <= r_phase + PH_W'(1);
    end else if (en) begin
      r_cnt   <= r_cnt + c_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_int  <= CNT_W'(DEF_INT);
      r_act_frac <= FRAC_W'(DEF_FRAC);
      r_sh_int   <= CNT_W'(DEF_INT);
      r_sh_frac  <= FRAC_W'(DEF_FRAC);
      r_pend     <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_int  <= r_sh_int;
        r_act_frac <= r_sh_frac;
      end
      if (div_load) begin
        r_sh_int  <= div_int;
        r_sh_frac <= div_frac;
        r_pend    <= 1'b1;
      end else if (w_apply) begin
        r_pend    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovs <= 1'b0;
      r_bit <= 1'b0;
      r_mid <= 1'b0;
      r_clk <= 1'b0;
    end else begin
      r_ovs <= !resync && w_wrap;
      r_bit <= !resync && w_wrap && (r_phase == c_PH_LAST);
      r_mid <= !resync && w_wrap && (r_phase == c_PH_MID_M1);
      if (resync || w_wrap) begin
        r_clk <= 1'b0;
      end else if (en && (r_cnt == w_half_m1)) begin
        r_clk <= 1'b1;
      end
    end
  end

  assign div_pend  = r_pend;
  assign ovs_tick  = r_ovs;
  assign bit_tick  = r_bit;
  assign mid_tick  = r_mid;
  assign ovs_phase = r_phase;
  assign clkout    = r_clk;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baud_tick_gen
//  Purpose  : Randomised self-checking bench for baud_tick_gen against a
//             period-countdown reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_baud_tick_gen;

  localparam int CNT_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OVS      = 16;
  localparam int DEF_INT  = 78;
  localparam int DEF_FRAC = 2;
  localparam int PH_W     = $clog2(OVS);

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              resync;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              div_pend;
  logic              ovs_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic [PH_W-1:0]   ovs_phase;
  logic              clkout;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .CNT_W(CNT_W), .FRAC_W(FRAC_W), .OVS(OVS),
    .DEF_INT(DEF_INT), .DEF_FRAC(DEF_FRAC)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .resync(resync),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .div_pend(div_pend), .ovs_tick(ovs_tick), .bit_tick(bit_tick),
    .mid_tick(mid_tick), .ovs_phase(ovs_phase), .clkout(clkout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each period is a countdown of its full length in cycles.
  int m_int, m_frac, m_sh_int, m_sh_frac;
  int m_acc, m_phase, m_left, m_plen, m_elapsed;
  bit m_pend, m_ovs, m_bit, m_mid, m_clk;

  function automatic int eff(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({div_pend, ovs_tick, bit_tick, mid_tick, clkout, ovs_phase});
  endfunction

  function automatic logic [31:0] model_outs();
    return 32'({m_pend, m_ovs, m_bit, m_mid, m_clk, PH_W'(m_phase)});
  endfunction

  task automatic model_reset();
    m_int = DEF_INT; m_frac = DEF_FRAC; m_sh_int = DEF_INT; m_sh_frac = DEF_FRAC;
    m_pend = 0; m_acc = 0; m_phase = 0; m_elapsed = 0;
    m_plen = eff(DEF_INT); m_left = m_plen;
    m_ovs = 0; m_bit = 0; m_mid = 0; m_clk = 0;
  endtask

  task automatic model_step();
    bit apply;
    int sum;
    apply = 0;
    m_ovs = 0; m_bit = 0; m_mid = 0;
    if (resync) begin
      apply = m_pend;
      if (apply) begin m_int = m_sh_int; m_frac = m_sh_frac; end
      m_acc = 0; m_phase = 0; m_elapsed = 0; m_clk = 0;
      m_plen = eff(m_int); m_left = m_plen;
    end else if (en) begin
      m_left--;
      if (m_left == 0) begin
        m_ovs = 1;
        m_bit = (m_phase == OVS - 1);
        m_mid = (m_phase == OVS / 2 - 1);
        m_phase = (m_phase + 1) % OVS;
        sum = m_acc + m_frac;
        if (m_pend) begin apply = 1; m_int = m_sh_int; m_frac = m_sh_frac; end
        m_plen = eff(m_int) + sum / (1 << FRAC_W);
        m_left = m_plen;
        m_acc = sum % (1 << FRAC_W);
        m_elapsed = 0; m_clk = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed >= eff(m_int) / 2) m_clk = 1;
      end
    end
    if (apply) m_pend = 0;
    if (div_load) begin m_sh_int = div_int; m_sh_frac = div_frac; m_pend = 1; end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk(tag, outs(), model_outs());
    @(negedge clk);
    div_load = 1'b0;
    resync   = 1'b0;
  endtask

  task automatic load(input int vi, input int vf);
    div_int  = CNT_W'(vi);
    div_frac = FRAC_W'(vf);
    div_load = 1'b1;
  endtask

  initial begin
    int first, tick_n, mid_at, bit_at;
    bit found;
    rst = 1'b1; en = 1'b1; resync = 1'b0; div_load = 1'b0;
    div_int = '0; div_frac = '0;
    model_reset();
    #1 chk("reset", outs(), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    repeat (20000) cyc("default");

    // Asynchronous reset on the last count of a 78-cycle period.
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (m_plen - m_left == 77) found = 1;
      else cyc("seek77");
    end
    chk("seek77_found", 32'(found), 32'd1);
    rst = 1'b1;
    #1 chk("rst_async", outs(), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 200; k++) begin
      cyc("after_rst");
      if (ovs_tick && first == 0) first = k;
    end
    chk("first_tick", 32'(first), 32'd78);

    repeat (40) cyc("pre104");
    load(104, 0);
    cyc("load104");
    repeat (600) cyc("div104");

    load(1, 0);
    cyc("load1");
    repeat (150) cyc("clamp");

    load(78, 2);
    cyc("load78");
    found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      if (m_phase == 9 && (m_plen - m_left) == 40 && !m_pend) found = 1;
      else cyc("seek_ph9");
    end
    chk("seek_ph9_found", 32'(found), 32'd1);
    resync = 1'b1;
    cyc("resync");
    first = 0; tick_n = 0; mid_at = 0; bit_at = 0;
    for (int k = 1; k <= 1400; k++) begin
      cyc("post_resync");
      if (ovs_tick) begin
        tick_n++;
        if (tick_n == 1) first = k;
        if (mid_tick && mid_at == 0) mid_at = tick_n;
        if (bit_tick && bit_at == 0) bit_at = tick_n;
      end
    end
    chk("resync_first", 32'(first), 32'd78);
    chk("resync_mid_idx", 32'(mid_at), 32'd8);
    chk("resync_bit_idx", 32'(bit_at), 32'd16);

    repeat (30) cyc("pre_hold");
    en = 1'b0;
    repeat (250) cyc("hold");
    load(50, 3);
    repeat (250) cyc("hold_load");
    chk("hold_pend", 32'(div_pend), 32'd1);
    en = 1'b1;
    repeat (400) cyc("resume");

    repeat (6000) begin
      en     = ($urandom_range(0, 9) != 0);
      resync = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 149) == 0) load($urandom_range(0, 12), $urandom_range(0, 15));
      cyc("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART datapath: divides the single system clock into an oversample tick stream, a bit tick and a mid-bit sample tick, with a fractional divisor for accurate rates from arbitrary clocks. The divisor is runtime-reprogrammable through a shadow register and applied only at a period boundary. A resync input realigns the phase to a receiver start-bit edge. A legacy square-wave `clkout` is kept for existing consumers. All outputs are clock enables, not derived clocks, except `clkout`.

## Interface
- `CNT_W`, 16: width of integer divisor and period counter.
- `FRAC_W`, 4: fractional divisor width; resolution 1/2^FRAC_W cycle.
- `OVS`, 16: oversample ticks per bit; power of two, ≥4.
- `DEF_INT`, 78: reset integer divisor (12 MHz / 9600 / 16).
- `DEF_FRAC`, 2: reset fractional divisor (78.125 exact at FRAC_W=4).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; low freezes all state.
- `resync`  in  1  synchronous phase restart (priority over `en`).
- `div_int`  in  CNT_W  new integer divisor.
- `div_frac`  in  FRAC_W  new fractional divisor.
- `div_load`  in  1  single-cycle strobe; captures `div_int`/`div_frac` into shadow.
- `div_pend`  out  1  shadow holds a value not yet applied.
- `ovs_tick`  out  1  one-cycle pulse per oversample period.
- `bit_tick`  out  1  one-cycle pulse per bit (every OVS-th `ovs_tick`).
- `mid_tick`  out  1  one-cycle pulse at bit centre.
- `ovs_phase`  out  log2(OVS)  current oversample index within the bit.
- `clkout`  out  1  ~50 % duty square wave at the oversample rate.

## Operation
- State: period counter `cnt`, active divisor (`act_int`, `act_frac`), shadow divisor and pending flag, fractional accumulator `acc` (FRAC_W bits), `ovs_phase`, and registered outputs.
- Reset: `cnt`=0, `acc`=0, `ovs_phase`=0, active = DEF_INT/DEF_FRAC, `div_pend`=0, all ticks 0, `clkout`=0.
- Effective integer `I` = max(`act_int`, 2); values 0/1 are clamped to 2.
- Period `P` = I+1 if the current period is flagged long, else I. Average period = I + `act_frac`/2^FRAC_W.
- With `en`=1, `cnt` increments. At `cnt`==P-1 (the "wrap"), `cnt`←0. `ovs_tick` is asserted in the following cycle.
- Fraction at wrap: {carry,`acc`} ← `acc` + `act_frac`. Carry=1 flags the next period as long.
- `ovs_phase` increments modulo OVS at each wrap.
  - `bit_tick` accompanies the `ovs_tick` whose wrap takes `ovs_phase` OVS-1→0.
  - `mid_tick` accompanies the wrap taking `ovs_phase` to OVS/2.
- `clkout`: set in the cycle after `cnt` reaches (I>>1)-1; cleared in the cycle after the wrap.
- Divisor update:
  - `div_load` captures the inputs into the shadow and sets `div_pend` next cycle.
  - A second load before application overwrites the shadow.
  - The shadow is copied to active at the first wrap strictly after the load edge; `div_pend` clears at that edge.
  - A load on the same edge as a wrap applies at the next wrap.
  - `acc` is not cleared on application.
- `resync`=1 (regardless of `en`):
  - `cnt`, `acc` and `ovs_phase` ← 0; `clkout` ← 0; all ticks 0 in the next cycle.
  - A pending shadow is applied immediately and `div_pend` clears.
  - Counting resumes from 0 on the following enabled edge.
- `en`=0: every register holds and the tick outputs are 0. A pending load remains pending. `div_load` is still captured.

## Timing
- All outputs are registered; no combinational input→output paths.
- After `rst` falls with `en`=1, the first `ovs_tick` is high in cycle DEF_INT (edges counted from 1), then every P cycles.
- `ovs_tick`, `bit_tick` and `mid_tick` are exactly one cycle wide. `bit_tick` and `mid_tick` are always coincident with an `ovs_tick`.
- Over any 2^FRAC_W consecutive oversample periods, total cycles = 2^FRAC_W·I + `act_frac`.
- `resync` to first `ovs_tick`: exactly I cycles after the `resync` edge, with `en` high.
- Asynchronous `rst` mid-period aborts immediately. No tick is produced on the reset cycle.

## Test plan
- Reset defaults (78/2, OVS=16), `en`=1 for 20000 cycles → `ovs_tick` gaps are 78 except every 8th gap, which is 79. `bit_tick` every 16 ticks. Ticks per 1250 cycles within ±1 of 16.
- Load `div_int`=104, `div_frac`=0 mid-period → `div_pend`=1 until the next wrap; the current period completes at the old length; all later gaps are 104.
- `div_int`=1 → clamped: `ovs_tick` every 2 cycles. `clkout` toggles with period 2.
- `resync` pulse with `ovs_phase`=9 and `cnt`=40 → `ovs_phase`=0. Next `ovs_tick` arrives 78 cycles later. `mid_tick` falls on the 8th `ovs_tick`, `bit_tick` on the 16th.
- `en` low for 500 cycles mid-period → no ticks during the hold. Resumed period length = the remaining count exactly. `div_load` during the hold remains pending until the next wrap.
- `rst` asserted when `cnt`=77 → all outputs 0 immediately. After release, the first `ovs_tick` arrives at cycle 78 with no spurious pulse.
